// File: rtl/layer_inter_pingpong_control.sv
// Ping-pong controller between a producer and a consumer CNN layer sharing two feature RAM banks.
// The producer fills empty banks while the consumer drains full ones, so both layers run concurrently.
`timescale 1ns/1ps
module layer_inter_pingpong_control #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  producer_done,
    input  logic                  consumer_done,
    input  logic                  wren_a_prod,
    input  logic                  wren_b_prod,
    input  logic [ADDR_WIDTH-1:0] address_a_prod,
    input  logic [ADDR_WIDTH-1:0] address_b_prod,
    input  logic                  rden_a_cons,
    input  logic                  rden_b_cons,
    input  logic [ADDR_WIDTH-1:0] address_a_cons,
    input  logic [ADDR_WIDTH-1:0] address_b_cons,
    output logic                  producer_enable,
    output logic                  producer_reset,
    output logic                  consumer_enable,
    output logic                  consumer_reset,
    output logic                  rden_a_bank0,
    output logic                  rden_b_bank0,
    output logic                  wren_a_bank0,
    output logic                  wren_b_bank0,
    output logic [ADDR_WIDTH-1:0] address_a_bank0,
    output logic [ADDR_WIDTH-1:0] address_b_bank0,
    output logic                  rden_a_bank1,
    output logic                  rden_b_bank1,
    output logic                  wren_a_bank1,
    output logic                  wren_b_bank1,
    output logic [ADDR_WIDTH-1:0] address_a_bank1,
    output logic [ADDR_WIDTH-1:0] address_b_bank1,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic [1:0]            full,
    output logic                  dbg_prod_state,
    output logic                  dbg_cons_state
);

    typedef enum logic {P_IDLE = 1'b0, P_RUN = 1'b1} prod_state_t;
    typedef enum logic {C_IDLE = 1'b0, C_RUN = 1'b1} cons_state_t;

    prod_state_t prod_q;
    cons_state_t cons_q;
    logic        wr_bank_q, rd_bank_q;
    logic [1:0]  full_q;
    logic        pdone_prev_q, cdone_prev_q;
    logic        prod_en_q, prod_rst_q, cons_en_q, cons_rst_q;

    logic pdone_rise, cdone_rise;
    assign pdone_rise = producer_done & ~pdone_prev_q;
    assign cdone_rise = consumer_done & ~cdone_prev_q;

    // Both FSMs share one block; they touch different full bits because the
    // producer only ever owns an empty bank and the consumer only a full one.
    always_ff @(posedge clock) begin
        if (reset) begin
            prod_q       <= P_IDLE;
            cons_q       <= C_IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= 2'b00;
            pdone_prev_q <= 1'b0;
            cdone_prev_q <= 1'b0;
            prod_en_q    <= 1'b0;
            prod_rst_q   <= 1'b0;
            cons_en_q    <= 1'b0;
            cons_rst_q   <= 1'b0;
        end else begin
            pdone_prev_q <= producer_done;
            cdone_prev_q <= consumer_done;

            case (prod_q)
                P_IDLE: begin
                    if (enable && !full_q[wr_bank_q]) begin
                        prod_q     <= P_RUN;
                        prod_en_q  <= 1'b1;
                        prod_rst_q <= 1'b1;
                    end
                end
                P_RUN: begin
                    prod_rst_q <= 1'b0;
                    if (pdone_rise) begin
                        full_q[wr_bank_q] <= 1'b1;
                        wr_bank_q         <= ~wr_bank_q;
                        prod_en_q         <= 1'b0;
                        prod_q            <= P_IDLE;
                    end
                end
                default: prod_q <= P_IDLE;
            endcase

            case (cons_q)
                C_IDLE: begin
                    if (enable && full_q[rd_bank_q]) begin
                        cons_q     <= C_RUN;
                        cons_en_q  <= 1'b1;
                        cons_rst_q <= 1'b1;
                    end
                end
                C_RUN: begin
                    cons_rst_q <= 1'b0;
                    if (cdone_rise) begin
                        full_q[rd_bank_q] <= 1'b0;
                        rd_bank_q         <= ~rd_bank_q;
                        cons_en_q         <= 1'b0;
                        cons_q            <= C_IDLE;
                    end
                end
                default: cons_q <= C_IDLE;
            endcase
        end
    end

    logic [1:0]            rden_a, rden_b, wren_a, wren_b;
    logic [ADDR_WIDTH-1:0] addr_a [2];
    logic [ADDR_WIDTH-1:0] addr_b [2];

    always_comb begin
        rden_a = 2'b00;
        rden_b = 2'b00;
        wren_a = 2'b00;
        wren_b = 2'b00;
        addr_a[0] = '0;
        addr_a[1] = '0;
        addr_b[0] = '0;
        addr_b[1] = '0;
        if (prod_q == P_RUN) begin
            wren_a[wr_bank_q] = wren_a_prod;
            wren_b[wr_bank_q] = wren_b_prod;
            addr_a[wr_bank_q] = address_a_prod;
            addr_b[wr_bank_q] = address_b_prod;
        end
        if (cons_q == C_RUN) begin
            rden_a[rd_bank_q] = rden_a_cons;
            rden_b[rd_bank_q] = rden_b_cons;
            addr_a[rd_bank_q] = address_a_cons;
            addr_b[rd_bank_q] = address_b_cons;
        end
    end

    assign rden_a_bank0    = rden_a[0];
    assign rden_b_bank0    = rden_b[0];
    assign wren_a_bank0    = wren_a[0];
    assign wren_b_bank0    = wren_b[0];
    assign address_a_bank0 = addr_a[0];
    assign address_b_bank0 = addr_b[0];
    assign rden_a_bank1    = rden_a[1];
    assign rden_b_bank1    = rden_b[1];
    assign wren_a_bank1    = wren_a[1];
    assign wren_b_bank1    = wren_b[1];
    assign address_a_bank1 = addr_a[1];
    assign address_b_bank1 = addr_b[1];

    assign producer_enable = prod_en_q;
    assign producer_reset  = prod_rst_q;
    assign consumer_enable = cons_en_q;
    assign consumer_reset  = cons_rst_q;
    assign wr_bank         = wr_bank_q;
    assign rd_bank         = rd_bank_q;
    assign full            = full_q;
    assign dbg_prod_state  = prod_q;
    assign dbg_cons_state  = cons_q;

endmodule

// File: tb/tb_layer_inter_pingpong_control.sv
// Directed bench for layer_inter_pingpong_control: walks reset, start, hand-off, stall,
// simultaneous done, held done and mid-run reset with hand-computed expectations.
`timescale 1ns/1ps
module tb_layer_inter_pingpong_control;
    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          reset, enable, producer_done, consumer_done;
    logic          wren_a_prod, wren_b_prod, rden_a_cons, rden_b_cons;
    logic [AW-1:0] address_a_prod, address_b_prod, address_a_cons, address_b_cons;
    logic          producer_enable, producer_reset, consumer_enable, consumer_reset;
    logic          rden_a_bank0, rden_b_bank0, wren_a_bank0, wren_b_bank0;
    logic          rden_a_bank1, rden_b_bank1, wren_a_bank1, wren_b_bank1;
    logic [AW-1:0] address_a_bank0, address_b_bank0, address_a_bank1, address_b_bank1;
    logic          wr_bank, rd_bank, dbg_prod_state, dbg_cons_state;
    logic [1:0]    full;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    layer_inter_pingpong_control #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .producer_done(producer_done), .consumer_done(consumer_done),
        .wren_a_prod(wren_a_prod), .wren_b_prod(wren_b_prod),
        .address_a_prod(address_a_prod), .address_b_prod(address_b_prod),
        .rden_a_cons(rden_a_cons), .rden_b_cons(rden_b_cons),
        .address_a_cons(address_a_cons), .address_b_cons(address_b_cons),
        .producer_enable(producer_enable), .producer_reset(producer_reset),
        .consumer_enable(consumer_enable), .consumer_reset(consumer_reset),
        .rden_a_bank0(rden_a_bank0), .rden_b_bank0(rden_b_bank0),
        .wren_a_bank0(wren_a_bank0), .wren_b_bank0(wren_b_bank0),
        .address_a_bank0(address_a_bank0), .address_b_bank0(address_b_bank0),
        .rden_a_bank1(rden_a_bank1), .rden_b_bank1(rden_b_bank1),
        .wren_a_bank1(wren_a_bank1), .wren_b_bank1(wren_b_bank1),
        .address_a_bank1(address_a_bank1), .address_b_bank1(address_b_bank1),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .full(full),
        .dbg_prod_state(dbg_prod_state), .dbg_cons_state(dbg_cons_state)
    );

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic pe, input logic pr,
                           input logic ce, input logic cr);
        #1;
        chk({tag, ".producer_enable"}, 32'(producer_enable), 32'(pe));
        chk({tag, ".producer_reset"},  32'(producer_reset),  32'(pr));
        chk({tag, ".consumer_enable"}, 32'(consumer_enable), 32'(ce));
        chk({tag, ".consumer_reset"},  32'(consumer_reset),  32'(cr));
    endtask

    task automatic chk_ptr(input string tag, input logic [1:0] f, input logic wb, input logic rb);
        chk({tag, ".full"},    32'(full),    32'(f));
        chk({tag, ".wr_bank"}, 32'(wr_bank), 32'(wb));
        chk({tag, ".rd_bank"}, 32'(rd_bank), 32'(rb));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; producer_done = 1'b0; consumer_done = 1'b0;
        wren_a_prod = 1'b1; wren_b_prod = 1'b0;
        address_a_prod = 9'h1A5; address_b_prod = 9'h033;
        rden_a_cons = 1'b1; rden_b_cons = 1'b1;
        address_a_cons = 9'h0FF; address_b_cons = 9'h155;

        // Reset state: nothing owned, so no input leaks onto either bank.
        tick(); tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ptr("reset", 2'b00, 1'b0, 1'b0);
        chk("reset.address_a_bank0", 32'(address_a_bank0), 32'h0);
        chk("reset.rden_a_bank1", 32'(rden_a_bank1), 32'h0);

        // First producer start.
        reset = 1'b0; enable = 1'b1;
        tick();
        chk_ctl("pstart", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pstart.address_a_bank0", 32'(address_a_bank0), 32'h1A5);
        chk("pstart.wren_a_bank0",    32'(wren_a_bank0),    32'h1);
        chk("pstart.address_b_bank0", 32'(address_b_bank0), 32'h033);
        chk("pstart.rden_a_bank0",    32'(rden_a_bank0),    32'h0);
        chk("pstart.address_a_bank1", 32'(address_a_bank1), 32'h0);
        chk("pstart.wren_a_bank1",    32'(wren_a_bank1),    32'h0);
        chk("pstart.rden_b_bank1",    32'(rden_b_bank1),    32'h0);
        tick();
        chk_ctl("prun", 1'b1, 1'b0, 1'b0, 1'b0);

        // Producer finishes bank0; consumer cannot start until the full bit is visible.
        producer_done = 1'b1;
        tick();
        chk_ctl("pdone1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ptr("pdone1", 2'b01, 1'b1, 1'b0);
        producer_done = 1'b0;
        tick();
        chk_ctl("handoff", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("handoff.address_a_bank0", 32'(address_a_bank0), 32'h0FF);
        chk("handoff.rden_a_bank0",    32'(rden_a_bank0),    32'h1);
        chk("handoff.address_b_bank0", 32'(address_b_bank0), 32'h155);
        chk("handoff.wren_a_bank0",    32'(wren_a_bank0),    32'h0);
        chk("handoff.address_a_bank1", 32'(address_a_bank1), 32'h1A5);
        chk("handoff.wren_a_bank1",    32'(wren_a_bank1),    32'h1);
        chk("handoff.rden_a_bank1",    32'(rden_a_bank1),    32'h0);
        address_a_prod = 9'h00C;
        #1 chk("handoff.passthru", 32'(address_a_bank1), 32'h00C);

        // Consumer stalls; producer fills bank1 and both banks are full.
        tick();
        chk_ctl("run2", 1'b1, 1'b0, 1'b1, 1'b0);
        producer_done = 1'b1;
        tick();
        chk_ptr("bothfull", 2'b11, 1'b0, 1'b0);
        producer_done = 1'b0;
        tick(); tick();
        chk_ctl("stall", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall.dbg_prod_state", 32'(dbg_prod_state), 32'h0);

        // Consumer drains bank0; producer restarts there two cycles after the edge.
        consumer_done = 1'b1;
        tick();
        chk_ctl("cdone1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ptr("cdone1", 2'b10, 1'b0, 1'b1);
        consumer_done = 1'b0;
        tick();
        chk_ctl("restart", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("restart.wren_a_bank0",    32'(wren_a_bank0),    32'h1);
        chk("restart.address_a_bank1", 32'(address_a_bank1), 32'h0FF);

        // Simultaneous done edges: bank0 becomes full, bank1 empty, both pointers toggle.
        tick();
        producer_done = 1'b1; consumer_done = 1'b1;
        tick();
        chk_ctl("simul", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ptr("simul", 2'b01, 1'b1, 1'b0);

        // Done levels held high: no further edges, so runs start and keep going.
        tick();
        chk_ctl("held1", 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); tick(); tick();
        chk_ctl("held5", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_ptr("held5", 2'b01, 1'b1, 1'b0);
        producer_done = 1'b0; consumer_done = 1'b0;
        tick();

        // Reset in the middle of both runs, then enable low keeps everything idle.
        reset = 1'b1;
        tick();
        chk_ctl("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ptr("midreset", 2'b00, 1'b0, 1'b0);
        chk("midreset.wren_a_bank1", 32'(wren_a_bank1), 32'h0);
        chk("midreset.rden_a_bank0", 32'(rden_a_bank0), 32'h0);
        reset = 1'b0; enable = 1'b0;
        tick(); tick();
        chk_ctl("noenable", 1'b0, 1'b0, 1'b0, 1'b0);

        // A done edge while idle must not mark a bank full.
        producer_done = 1'b1;
        tick();
        producer_done = 1'b0;
        tick();
        chk_ptr("idledone", 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
